// File: rtl/mux_sequencial_if.sv
// Output stream of mux_sequencial: valid/ready handshake plus the held word and its tags.
interface mux_sequencial_if #(
  parameter int unsigned LARGURA = 8,
  parameter int unsigned CANAIS  = 8
);
  localparam int unsigned END_W = $clog2(CANAIS);

  logic               pronto_saida;
  logic               valido_saida;
  logic [LARGURA-1:0] dados_selecionados;
  logic [END_W-1:0]   canal_atual;
  logic               erro_endereco;
  logic               varredura_completa;

  modport master (
    input  pronto_saida,
    output valido_saida,
    output dados_selecionados,
    output canal_atual,
    output erro_endereco,
    output varredura_completa
  );

  modport slave (
    output pronto_saida,
    input  valido_saida,
    input  dados_selecionados,
    input  canal_atual,
    input  erro_endereco,
    input  varredura_completa
  );
endinterface

// File: rtl/mux_sequencial.sv
// Registered N-channel multiplexer with manual/scan modes and a valid/ready output stage.
// Optional channel mask for scan mode enabled by defining MUX_MASCARA_EN.
module mux_sequencial #(
  parameter  int unsigned LARGURA = 8,
  parameter  int unsigned CANAIS  = 8,
  localparam int unsigned END_W   = $clog2(CANAIS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CANAIS*LARGURA-1:0] entradas,
  input  logic [END_W-1:0]          endereco,
  input  logic                      modo,
`ifdef MUX_MASCARA_EN
  input  logic [CANAIS-1:0]         mascara,
`endif
  mux_sequencial_if.master          saida
);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} estado_t;

  estado_t            estado_q;
  logic               valido_q;
  logic [LARGURA-1:0] dados_q;
  logic [END_W-1:0]   canal_q;
  logic               erro_q;
  logic               fim_q;
  logic [END_W-1:0]   ptr_q;

  logic [LARGURA-1:0] canal_arr [CANAIS];
  logic [CANAIS-1:0]  hab_c;
  logic               fora_c;
  logic [LARGURA-1:0] dado_man_c;
  logic               carga_c;
  logic [END_W-1:0]   base_c;
  logic [END_W-1:0]   prim_c;
  logic [END_W-1:0]   ult_c;
  logic [END_W-1:0]   sel_c;
  logic [END_W-1:0]   nxt_c;
  logic               tem_c;
  logic               achou_sel_c;
  logic               achou_nxt_c;

  for (genvar k = 0; k < int'(CANAIS); k++) begin : g_canal
    assign canal_arr[k] = entradas[k*LARGURA +: LARGURA];
  end

`ifdef MUX_MASCARA_EN
  assign hab_c = mascara;
`else
  assign hab_c = '1;
`endif

  // Out-of-range addresses only exist when CANAIS is not a power of two.
  if (CANAIS == (32'd1 << END_W)) begin : g_pot
    assign fora_c = 1'b0;
  end else begin : g_npot
    assign fora_c = (32'(endereco) >= CANAIS);
  end

  assign dado_man_c = fora_c ? '0 : canal_arr[endereco];
  assign carga_c    = !valido_q || saida.pronto_saida;

  // Scan selection: first enabled channel at/above the pointer, and the one after it (wrapping).
  always_comb begin
    base_c      = (estado_q == SCAN) ? ptr_q : '0;
    prim_c      = '0;
    ult_c       = '0;
    sel_c       = '0;
    nxt_c       = '0;
    tem_c       = 1'b0;
    achou_sel_c = 1'b0;
    achou_nxt_c = 1'b0;
    for (int unsigned i = 0; i < CANAIS; i++) begin
      if (hab_c[i]) begin
        if (!tem_c) prim_c = END_W'(i);
        tem_c = 1'b1;
        ult_c = END_W'(i);
        if (!achou_sel_c && (i >= 32'(base_c))) begin
          sel_c       = END_W'(i);
          achou_sel_c = 1'b1;
        end
      end
    end
    if (!achou_sel_c) sel_c = prim_c;
    for (int unsigned i = 0; i < CANAIS; i++) begin
      if (hab_c[i] && !achou_nxt_c && (i > 32'(sel_c))) begin
        nxt_c       = END_W'(i);
        achou_nxt_c = 1'b1;
      end
    end
    if (!achou_nxt_c) nxt_c = prim_c;
  end

  // Mode FSM and output register; the pointer always holds the next scan channel to load.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= MANUAL;
      valido_q <= 1'b0;
      dados_q  <= '0;
      canal_q  <= '0;
      erro_q   <= 1'b0;
      fim_q    <= 1'b0;
      ptr_q    <= '0;
    end else if (carga_c) begin
      if (modo) begin
        estado_q <= SCAN;
        if (tem_c) begin
          valido_q <= 1'b1;
          dados_q  <= canal_arr[sel_c];
          canal_q  <= sel_c;
          erro_q   <= 1'b0;
          fim_q    <= (sel_c == ult_c);
          ptr_q    <= nxt_c;
        end else begin
          valido_q <= 1'b0;
          fim_q    <= 1'b0;
        end
      end else begin
        estado_q <= MANUAL;
        valido_q <= 1'b1;
        dados_q  <= dado_man_c;
        canal_q  <= endereco;
        erro_q   <= fora_c;
        fim_q    <= 1'b0;
      end
    end
  end

  assign saida.valido_saida       = valido_q;
  assign saida.dados_selecionados = dados_q;
  assign saida.canal_atual        = canal_q;
  assign saida.erro_endereco      = erro_q;
  // Must coincide with the transfer cycle itself, so it is qualified by the live ready.
  assign saida.varredura_completa = valido_q && saida.pronto_saida && fim_q && !rst;

endmodule

// File: tb/tb_mux_sequencial.sv
// Directed self-checking bench: an 8-channel and a 6-channel instance of mux_sequencial.
module tb_mux_sequencial;

  logic        clk;
  logic        rst;
  logic [63:0] entradas_a;
  logic [2:0]  endereco_a;
  logic        modo_a;
  logic [47:0] entradas_b;
  logic [2:0]  endereco_b;
  logic        modo_b;
`ifdef MUX_MASCARA_EN
  logic [7:0]  mascara_a;
  logic [5:0]  mascara_b;
`endif

  int checks;
  int failures;
  logic [13:0] obs;
  logic [13:0] exp_v;

  mux_sequencial_if #(.LARGURA(8), .CANAIS(8)) ifa ();
  mux_sequencial_if #(.LARGURA(8), .CANAIS(6)) ifb ();

  mux_sequencial #(.LARGURA(8), .CANAIS(8)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .entradas (entradas_a),
    .endereco (endereco_a),
    .modo     (modo_a),
`ifdef MUX_MASCARA_EN
    .mascara  (mascara_a),
`endif
    .saida    (ifa)
  );

  mux_sequencial #(.LARGURA(8), .CANAIS(6)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .entradas (entradas_b),
    .endereco (endereco_b),
    .modo     (modo_b),
`ifdef MUX_MASCARA_EN
    .mascara  (mascara_b),
`endif
    .saida    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
    checks++;
    if (obs !== 14'h0) begin
      $display("FAIL reset_a got=%h exp=%h", obs, 14'h0);
      failures++;
    end
    obs = {ifb.valido_saida, ifb.dados_selecionados, ifb.canal_atual, ifb.erro_endereco, ifb.varredura_completa};
    checks++;
    if (obs !== 14'h0) begin
      $display("FAIL reset_b got=%h exp=%h", obs, 14'h0);
      failures++;
    end
    rst = 1'b0;
  endtask

  task automatic test_manual();
    modo_a = 1'b0;
    ifa.pronto_saida = 1'b1;
    for (int e = 0; e < 8; e++) begin
      endereco_a = 3'(e);
      @(negedge clk);
      obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
      exp_v = {1'b1, 8'(1 << e), 3'(e), 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL manual e=%0d got=%h exp=%h", e, obs, exp_v);
        failures++;
      end
    end
  endtask

  task automatic test_backpressure();
    endereco_a = 3'd3;
    @(negedge clk);
    ifa.pronto_saida = 1'b0;
    endereco_a = 3'd6;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
      exp_v = {1'b1, 8'h08, 3'd3, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL hold c=%0d got=%h exp=%h", c, obs, exp_v);
        failures++;
      end
    end
    endereco_a = 3'd5;
    ifa.pronto_saida = 1'b1;
    @(negedge clk);
    obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
    exp_v = {1'b1, 8'h20, 3'd5, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL release got=%h exp=%h", obs, exp_v);
      failures++;
    end
  endtask

  task automatic test_scan();
    modo_a = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
      exp_v = {1'b1, 8'(1 << (k % 8)), 3'(k % 8), 1'b0, (k % 8) == 7};
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL scan k=%0d got=%h exp=%h", k, obs, exp_v);
        failures++;
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    repeat (5) @(negedge clk);
    obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
    exp_v = {1'b1, 8'h10, 3'd4, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL scan_ch4 got=%h exp=%h", obs, exp_v);
      failures++;
    end
    ifa.pronto_saida = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    obs = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
    checks++;
    if (obs !== 14'h0) begin
      $display("FAIL mid_reset got=%h exp=%h", obs, 14'h0);
      failures++;
    end
    rst = 1'b0;
    ifa.pronto_saida = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
      exp_v = {1'b1, 8'(1 << k), 3'(k), 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL post_reset k=%0d got=%h exp=%h", k, obs, exp_v);
        failures++;
      end
    end
  endtask

  task automatic test_mode_switch();
    ifa.pronto_saida = 1'b0;
    modo_a = 1'b0;
    endereco_a = 3'd6;
    @(negedge clk);
    obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
    exp_v = {1'b1, 8'h02, 3'd1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL switch_hold got=%h exp=%h", obs, exp_v);
      failures++;
    end
    ifa.pronto_saida = 1'b1;
    @(negedge clk);
    obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
    exp_v = {1'b1, 8'h40, 3'd6, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL to_manual got=%h exp=%h", obs, exp_v);
      failures++;
    end
    modo_a = 1'b1;
    @(negedge clk);
    obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
    exp_v = {1'b1, 8'h01, 3'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL reenter_scan got=%h exp=%h", obs, exp_v);
      failures++;
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0]  ends [4];
    logic [13:0] exps [4];
    ends[0] = 3'd7; exps[0] = {1'b1, 8'h00, 3'd7, 1'b1, 1'b0};
    ends[1] = 3'd2; exps[1] = {1'b1, 8'h12, 3'd2, 1'b0, 1'b0};
    ends[2] = 3'd6; exps[2] = {1'b1, 8'h00, 3'd6, 1'b1, 1'b0};
    ends[3] = 3'd5; exps[3] = {1'b1, 8'h15, 3'd5, 1'b0, 1'b0};
    modo_b = 1'b0;
    ifb.pronto_saida = 1'b1;
    for (int v = 0; v < 4; v++) begin
      endereco_b = ends[v];
      @(negedge clk);
      obs = {ifb.valido_saida, ifb.dados_selecionados, ifb.canal_atual, ifb.erro_endereco, ifb.varredura_completa};
      checks++;
      if (obs !== exps[v]) begin
        $display("FAIL range v=%0d got=%h exp=%h", v, obs, exps[v]);
        failures++;
      end
    end
  endtask

  task automatic test_scan_6();
    modo_b = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      obs   = {ifb.valido_saida, ifb.dados_selecionados, ifb.canal_atual, ifb.erro_endereco, ifb.varredura_completa};
      exp_v = {1'b1, 8'h10 + 8'(k % 6), 3'(k % 6), 1'b0, (k % 6) == 5};
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL scan6 k=%0d got=%h exp=%h", k, obs, exp_v);
        failures++;
      end
    end
  endtask

`ifdef MUX_MASCARA_EN
  task automatic test_mascara();
    logic [2:0] ordem [6];
    ordem[0] = 3'd0; ordem[1] = 3'd2; ordem[2] = 3'd5;
    ordem[3] = 3'd7; ordem[4] = 3'd0; ordem[5] = 3'd2;
    rst = 1'b1;
    modo_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mascara_a = 8'b1010_0101;
    modo_a = 1'b1;
    ifa.pronto_saida = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      obs   = {ifa.valido_saida, ifa.dados_selecionados, ifa.canal_atual, ifa.erro_endereco, ifa.varredura_completa};
      exp_v = {1'b1, 8'(1 << ordem[k]), ordem[k], 1'b0, ordem[k] == 3'd7};
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL mask k=%0d got=%h exp=%h", k, obs, exp_v);
        failures++;
      end
    end
    mascara_a = 8'h00;
    @(negedge clk);
    checks++;
    if (ifa.valido_saida !== 1'b0) begin
      $display("FAIL mask_zero valido got=%b exp=%b", ifa.valido_saida, 1'b0);
      failures++;
    end
    mascara_a = 8'hFF;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    modo_a = 1'b0;
    endereco_a = 3'd0;
    modo_b = 1'b0;
    endereco_b = 3'd0;
    ifa.pronto_saida = 1'b1;
    ifb.pronto_saida = 1'b1;
`ifdef MUX_MASCARA_EN
    mascara_a = 8'hFF;
    mascara_b = 6'h3F;
`endif
    for (int k = 0; k < 8; k++) entradas_a[k*8 +: 8] = 8'(1 << k);
    for (int k = 0; k < 6; k++) entradas_b[k*8 +: 8] = 8'h10 + 8'(k);

    test_reset();
    test_manual();
    test_backpressure();
    test_scan();
    test_reset_mid_scan();
    test_mode_switch();
    test_out_of_range();
    test_scan_6();
`ifdef MUX_MASCARA_EN
    test_mascara();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
